// File: rtl/stream_packer.sv
// stream_packer: packs PACK valid samples per word into a show-ahead FIFO with overflow reporting.
// Revision 1.0
`default_nettype none

module stream_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  input  logic                       i_flush,
  output logic [WIDTH*PACK-1:0]      o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic [7:0]                 o_drop_cnt
);

  localparam int CW = $clog2(PACK);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int OW = WIDTH * PACK;

  logic [CW-1:0]  cnt;
  logic [OW-1:0]  lanes;
  logic [OW-1:0]  packed_word;
  logic           push_req;
  logic           pop;
  logic           full;
  logic           push_ok;
  logic           drop;

  logic [OW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic           overflow;
  logic [7:0]     drop_cnt;

  // The pushed word must already contain a sample arriving in the same cycle.
  always_comb begin
    packed_word = lanes;
    for (int k = 0; k < PACK; k++) begin
      if (i_valid && cnt == CW'(k)) begin
        packed_word[k*WIDTH +: WIDTH] = i_data;
      end
    end
  end

  assign push_req = (i_valid && cnt == CW'(PACK - 1)) ||
                    (i_flush && (cnt != '0 || i_valid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (push_req) begin
      cnt   <= '0;
      lanes <= '0;
    end else if (i_valid) begin
      cnt   <= cnt + CW'(1);
      lanes <= packed_word;
    end
  end

  assign pop     = (level != '0) && i_ready;
  assign full    = (level == LW'(DEPTH));
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= packed_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  assign o_data     = mem[rd_ptr];
  assign o_valid    = (level != '0);
  assign o_level    = level;
  assign o_overflow = overflow;
  assign o_drop_cnt = drop_cnt;

`ifndef SYNTHESIS
`ifndef __ICARUS__
  a_level_bound: assert property (@(posedge clk) disable iff (!rst) o_level <= LW'(DEPTH));
  a_drop_mono:   assert property (@(posedge clk) disable iff (!rst) o_drop_cnt >= $past(o_drop_cnt));
  a_valid_level: assert property (@(posedge clk) disable iff (!rst) !o_valid || (o_level != '0));
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_packer.sv
// tb_stream_packer: randomized and directed checks of stream_packer against a queue-based model.
// Revision 1.0
`default_nettype none

module tb_stream_packer;

  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int DEPTH = 4;
  localparam int OW    = WIDTH * PACK;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_valid = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_ready = 1'b0;
  logic [OW-1:0]    o_data;
  logic             o_valid;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic [7:0]       o_drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: pending samples and stored words as plain queues.
  logic [WIDTH-1:0] part[$];
  logic [OW-1:0]    fifo[$];
  bit               m_over = 1'b0;
  int               m_drops = 0;

  stream_packer #(.WIDTH(WIDTH), .PACK(PACK), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock(input bit r, input bit v, input logic [WIDTH-1:0] d,
                             input bit f, input bit rdy);
    bit            do_pop;
    bit            was_full;
    bit            do_push;
    logic [OW-1:0] word;
    if (!r) begin
      part.delete();
      fifo.delete();
      m_over  = 1'b0;
      m_drops = 0;
      return;
    end
    do_pop   = (fifo.size() > 0) && rdy;
    was_full = (fifo.size() == DEPTH);
    do_push  = 1'b0;
    word     = '0;
    if (v) part.push_back(d);
    if (part.size() == PACK || (f && part.size() > 0)) begin
      foreach (part[k]) word = word | (OW'(part[k]) << (k * WIDTH));
      part.delete();
      do_push = 1'b1;
    end
    if (do_pop) void'(fifo.pop_front());
    if (do_push) begin
      if (was_full && !do_pop) begin
        m_over = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        fifo.push_back(word);
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 64'(o_valid), 64'(fifo.size() > 0));
    check("level", 64'(o_level), 64'(fifo.size()));
    if (fifo.size() > 0) check("data", 64'(o_data), 64'(fifo[0]));
    check("overflow", 64'(o_overflow), 64'(m_over));
    check("drop_cnt", 64'(o_drop_cnt), 64'(m_drops));
  endtask

  // Inputs change at the falling edge; outputs are compared at the following falling edge.
  task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d,
                      input bit f, input bit rdy);
    rst     = r;
    i_valid = v;
    i_data  = d;
    i_flush = f;
    i_ready = rdy;
    @(posedge clk);
    model_clock(r, v, d, f, rdy);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    @(negedge clk);

    // Reset held with random traffic
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      check("rst_data", 64'(o_data), 64'h0);
      check("rst_valid", 64'(o_valid), 64'h0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
      check("post_rst_valid", 64'(o_valid), 64'h0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Basic pack
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    check("pack_not_early", 64'(o_valid), 64'h0);
    step(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    check("pack_valid", 64'(o_valid), 64'h1);
    check("pack_word", 64'(o_data), 64'h44332211);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("pack_drained", 64'(o_level), 64'h0);

    // Gapped samples then flush
    step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("flush_word", 64'(o_data), 64'h0000BBAA);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("flush_noop", 64'(o_valid), 64'h0);

    // Flush with same-cycle sample
    step(1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h02, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    check("flush_same", 64'(o_data), 64'h00030201);
    for (int i = 5; i <= 8; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
    check("fresh_word", 64'(o_data), 64'h08070605);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Overflow with a stalled consumer
    for (int i = 0; i < 6 * PACK; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check("ovf_level", 64'(o_level), 64'd4);
    check("ovf_flag", 64'(o_overflow), 64'h1);
    check("ovf_drops", 64'(o_drop_cnt), 64'd2);
    check("ovf_head", 64'(o_data), 64'h43424140);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_sticky", 64'(o_overflow), 64'h1);

    // Push and pop together while full
    for (int i = 0; i < 4 * PACK; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
    check("full_pp_level", 64'(o_level), 64'd4);
    check("full_pp_drops", 64'(o_drop_cnt), 64'd2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("full_pp_fourth", 64'(o_data), 64'hC3C2C1C0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      step((i == 700) ? 1'b0 : 1'b1,
           1'($urandom_range(0, 3) != 0),
           8'($urandom),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    // Drop counter saturation
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 1100; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
    check("drop_sat", 64'(o_drop_cnt), 64'd255);
    check("drop_sat_flag", 64'(o_overflow), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Receive side for the team's delay-line stream (WIDTH-bit data plus valid, no backpressure upstream).
- Collects PACK consecutive valid samples into one wide word, then buffers words in a DEPTH-entry FIFO.
- Presents words downstream with a valid/ready handshake.
- Upstream cannot be stalled, so lost words are reported through a sticky overflow flag and a drop counter.

Parameters:
- WIDTH, 8: bits per input sample.
- PACK, 4: samples per output word, ≥2.
- DEPTH, 4: FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_data  in  WIDTH  input sample.
- i_valid  in  1  i_data is valid this cycle.
- i_flush  in  1  close the current partial word and push it.
- o_data  out  WIDTH*PACK  packed word at the FIFO head.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: at least one word dropped.
- o_drop_cnt  out  8  dropped-word count, saturates at 255.

Behaviour:
Reset:
- rst low asynchronously clears the lane counter, all lane registers, FIFO storage, and both pointers.
- Outputs in reset: o_valid=0, o_data=0, o_level=0, o_overflow=0, o_drop_cnt=0.
- Reset mid-word or mid-drain discards all data. No word is emitted after release until PACK new samples arrive.

Packing:
- Lane counter cnt runs 0..PACK-1.
- On i_valid, i_data is written to lane cnt, occupying bits [cnt*WIDTH +: WIDTH]. Lane 0 is the LSB, so the first sample is the LSB.
- A push request is raised in the same cycle when i_valid && cnt==PACK-1. The pushed word includes the current sample. cnt then wraps to 0.
- i_valid=0 holds cnt and the lanes.

Flush:
- i_flush with cnt>0, or with i_valid, raises a push request.
- The word contains every sample received so far, including a same-cycle i_valid sample. Unfilled lanes are 0.
- cnt returns to 0 and the lanes are cleared.
- i_flush with cnt==0 and i_valid=0 is a no-op.
- i_flush coinciding with cnt==PACK-1 && i_valid produces exactly one push.

FIFO:
- Show-ahead: o_data is the head entry, o_valid = (o_level != 0).
- A pop occurs when o_valid && i_ready. Pops are never blocked.
- A push writes on the clock edge, so latency from the completing sample to o_valid is 1 cycle into an empty FIFO.
- o_data stays stable while o_valid && !i_ready.
- Pointers wrap modulo DEPTH.

Full and simultaneous events:
- Push while o_level==DEPTH with no pop in the same cycle: the word is dropped, o_overflow is set (sticky until reset), and o_drop_cnt increments, saturating at 255.
- Push and pop in the same cycle while full: both succeed and o_level stays DEPTH.
- Push and pop in the same cycle while empty: no pop, since o_valid=0. The push succeeds and o_level becomes 1.
- o_level changes by +1 on push only, -1 on pop only, 0 on both.

Assertions (non-Icarus builds):
- o_level ≤ DEPTH.
- o_drop_cnt never decreases.
- o_valid implies o_level>0.

Test Plan:
1. Reset: hold rst=0 with random i_valid/i_data -> o_valid=0, o_data=0, o_level=0, o_overflow=0. Release rst, send 3 samples -> o_valid stays 0.
2. Basic pack: i_ready=1, samples 0x11,0x22,0x33,0x44 on consecutive cycles -> o_valid=1 exactly one cycle after 0x44, o_data=0x44332211, o_level returns to 0 after the pop.
3. Gapped valid plus flush: samples 0xAA, idle 2 cycles, 0xBB, then i_flush alone -> one word 0x0000BBAA. A second i_flush with nothing pending produces no word.
4. Flush with a same-cycle sample: 0x01,0x02, then 0x03 with i_flush -> word 0x00030201. Next 4 samples form a fresh full word.
5. Overflow: i_ready=0, 6 full words pushed (DEPTH=4) -> o_level=4, o_overflow=1, o_drop_cnt=2. Then i_ready=1 -> the first 4 words drain in order, and the flag stays set.
6. Full push and pop: FIFO full, i_ready=1 while a word completes -> o_level stays 4, no drop, and the new word appears as the 4th output after the existing entries.
